// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - Instruction fetch stage: PC, single-outstanding imem requests, decode buffer, redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i,
    input  logic        redir_valid_i,
    input  logic [2:0]  npc_op_i,
    input  logic [31:0] redir_pc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_imm_i,
    input  logic [25:0] j_index_i,
    input  logic [31:0] jr_target_i
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_pc_q;
    logic        buf_valid_q;
    logic [31:0] p4, redir_target;
    logic        req_fire;
    logic        unused_bits;

    assign p4          = redir_pc_i + 32'd4;
    assign unused_bits = ^{br_imm_i[31:30], jr_target_i[1:0]};

    always_comb begin
        redir_target = p4;
        case (npc_op_i)
            3'b010:  redir_target = br_taken_i ? p4 + {br_imm_i[29:0], 2'b00} : p4;
            3'b011:  redir_target = {p4[31:28], j_index_i, 2'b00};
            3'b100:  redir_target = {jr_target_i[31:2], 2'b00};
            default: redir_target = p4;
        endcase
    end

    // A new request only goes out when the buffer is empty or draining this cycle.
    assign imem_req_o  = (state_q == S_REQ) && !rst && (!buf_valid_q || id_ready_i);
    assign imem_addr_o = pc_q;
    assign req_fire    = imem_req_o && imem_ready_i;

    assign id_valid_o = buf_valid_q;
    assign id_inst_o  = id_inst_q;
    assign id_pc_o    = id_pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redir_valid_i)
            pc_d = redir_target;
        else if (state_q == S_WAIT && imem_rvalid_i)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            id_inst_q   <= 32'd0;
            id_pc_q     <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (redir_valid_i) begin
                // Any fetch still in flight belongs to the squashed path.
                buf_valid_q <= 1'b0;
                case (state_q)
                    S_REQ:   state_q <= req_fire ? S_DROP : S_REQ;
                    S_WAIT,
                    S_DROP:  state_q <= imem_rvalid_i ? S_REQ : S_DROP;
                    default: state_q <= S_REQ;
                endcase
            end else begin
                if (buf_valid_q && id_ready_i)
                    buf_valid_q <= 1'b0;
                case (state_q)
                    S_REQ: begin
                        if (req_fire)
                            state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rvalid_i) begin
                            buf_valid_q <= 1'b1;
                            id_inst_q   <= imem_rdata_i;
                            id_pc_q     <= pc_q;
                            state_q     <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem_rvalid_i)
                            state_q <= S_REQ;
                    end
                    default: state_q <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [2:0]  npc_op;
    logic [31:0] redir_pc;
    logic        br_taken;
    logic [31:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] jr_target;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model state
    int          mem_lat = 1;
    bit          pend    = 0;
    int          cnt     = 0;
    logic [31:0] paddr   = 32'd0;
    bit          ovr_en  = 0;
    bit          stray   = 0;

    ifetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .id_valid_o(id_valid), .id_inst_o(id_inst), .id_pc_o(id_pc), .id_ready_i(id_ready),
        .redir_valid_i(redir_valid), .npc_op_i(npc_op), .redir_pc_i(redir_pc),
        .br_taken_i(br_taken), .br_imm_i(br_imm), .j_index_i(j_index), .jr_target_i(jr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Memory answers `mem_lat` cycles after acceptance; evaluated on negedge so
    // the request seen is the one the DUT samples at the next posedge.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ovr_en ? 32'hDEAD_BEEF : mem_word(paddr);
                pend        = 0;
            end
        end
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        if (imem_req && imem_ready) begin
            pend  = 1;
            cnt   = mem_lat;
            paddr = imem_addr;
        end
    end

    task automatic do_reset();
        rst = 1'b1; redir_valid = 1'b0; stray = 0; ovr_en = 0; id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic apply_redir(input logic [2:0] op, input logic [31:0] rpc, input logic taken,
                               input logic [31:0] imm, input logic [25:0] jidx, input logic [31:0] jrt);
        redir_valid = 1'b1; npc_op = op; redir_pc = rpc; br_taken = taken;
        br_imm = imm; j_index = jidx; jr_target = jrt;
        @(posedge clk);
        #1 redir_valid = 1'b0;
        #1;
    endtask

    task automatic wait_req(output logic [31:0] addr, output bit ok);
        ok = 0; addr = 32'hx;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin ok = 1; addr = imem_addr; break; end
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (id_valid) begin ok = 1; break; end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hBFC0_0000; exp_pc[1] = 32'hBFC0_0004; exp_pc[2] = 32'hBFC0_0008;
        mem_lat = 1;
        rst = 1'b1; redir_valid = 1'b0; id_ready = 1'b1;
        @(posedge clk); #2;
        n_tests++;
        if ({id_valid, imem_req, id_pc, id_inst} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b req=%b pc=%h inst=%h expected 0 0 0 0", id_valid, imem_req, id_pc, id_inst);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'hBFC0_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL first_fetch: req=%b addr=%h valid=%b expected 1 bfc00000 0", imem_req, imem_addr, id_valid);
        end
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #2;
            n_tests++;
            if (i % 2 == 0) begin
                if ({id_valid, id_pc, id_inst} !== {1'b1, exp_pc[i/2-1], mem_word(exp_pc[i/2-1])}) begin
                    n_fail++;
                    $display("FAIL seq_valid[%0d]: valid=%b pc=%h inst=%h expected pc=%h", i, id_valid, id_pc, id_inst, exp_pc[i/2-1]);
                end
            end else if (id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_gap[%0d]: valid=%b expected 0", i, id_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        repeat (4) begin @(posedge clk); #2; end
        n_tests++;
        if ({id_valid, id_pc} !== {1'b1, 32'hBFC0_0004}) begin
            n_fail++;
            $display("FAIL bp_start: valid=%b pc=%h expected 1 bfc00004", id_valid, id_pc);
        end
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({id_valid, id_pc, id_inst, imem_req} !== {1'b1, 32'hBFC0_0004, mem_word(32'hBFC0_0004), 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b pc=%h inst=%h req=%b", i, id_valid, id_pc, id_inst, imem_req);
            end
            @(posedge clk); #2;
        end
        id_ready = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hBFC0_0008}) begin
            n_fail++;
            $display("FAIL bp_release: req=%b addr=%h expected 1 bfc00008", imem_req, imem_addr);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        n_tests++;
        if ({id_valid, id_pc} !== {1'b1, 32'hBFC0_0008}) begin
            n_fail++;
            $display("FAIL bp_next: valid=%b pc=%h expected 1 bfc00008", id_valid, id_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        bit ok;
        mem_lat = 1;
        do_reset();
        repeat (2) begin @(posedge clk); #2; end
        apply_redir(3'b010, 32'hBFC0_0010, 1'b1, 32'hFFFF_FFFC, 26'd0, 32'd0);
        n_tests++;
        if (id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_taken_flush: valid=%b expected 0", id_valid);
        end
        wait_req(a, ok);
        n_tests++;
        if (!ok || a !== 32'hBFC0_0004) begin
            n_fail++;
            $display("FAIL br_taken_target: ok=%0d addr=%h expected bfc00004", ok, a);
        end
        apply_redir(3'b010, 32'hBFC0_0010, 1'b0, 32'hFFFF_FFFC, 26'd0, 32'd0);
        wait_req(a, ok);
        n_tests++;
        if (!ok || a !== 32'hBFC0_0014) begin
            n_fail++;
            $display("FAIL br_not_taken_target: ok=%0d addr=%h expected bfc00014", ok, a);
        end
        wait_valid(ok);
        n_tests++;
        if (!ok || id_pc !== 32'hBFC0_0014 || id_inst !== mem_word(32'hBFC0_0014)) begin
            n_fail++;
            $display("FAIL br_first_inst: ok=%0d pc=%h inst=%h expected bfc00014", ok, id_pc, id_inst);
        end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        bit ok;
        mem_lat = 1;
        do_reset();
        apply_redir(3'b011, 32'hBFC0_0020, 1'b0, 32'd0, 26'h000_0100, 32'd0);
        wait_req(a, ok);
        n_tests++;
        if (!ok || a !== 32'hB000_0400) begin
            n_fail++;
            $display("FAIL j_target: ok=%0d addr=%h expected b0000400", ok, a);
        end
        apply_redir(3'b100, 32'hBFC0_0020, 1'b0, 32'd0, 26'd0, 32'h8000_1233);
        wait_req(a, ok);
        n_tests++;
        if (!ok || a !== 32'h8000_1230) begin
            n_fail++;
            $display("FAIL jr_target: ok=%0d addr=%h expected 80001230", ok, a);
        end
        apply_redir(3'b111, 32'hBFC0_0040, 1'b1, 32'h0000_0010, 26'h3FF_FFFF, 32'd0);
        wait_req(a, ok);
        n_tests++;
        if (!ok || a !== 32'hBFC0_0044) begin
            n_fail++;
            $display("FAIL undef_op_pc4: ok=%0d addr=%h expected bfc00044", ok, a);
        end
        apply_redir(3'b100, 32'd0, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFE);
        wait_valid(ok);
        n_tests++;
        if (!ok || id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0000_0000 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: ok=%0d id_pc=%h next_addr=%h req=%b expected fffffffc 00000000 1", ok, id_pc, imem_addr, imem_req);
        end
    endtask

    task automatic test_drop_latency();
        bit ok;
        mem_lat = 3;
        do_reset();
        ovr_en = 1;
        @(posedge clk); #2;
        apply_redir(3'b100, 32'd0, 1'b0, 32'd0, 26'd0, 32'h8000_0100);
        n_tests++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_wait1: valid=%b req=%b expected 0 0", id_valid, imem_req);
        end
        @(posedge clk); #2;
        n_tests++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_wait2: valid=%b req=%b expected 0 0", id_valid, imem_req);
        end
        @(posedge clk); #2;
        ovr_en = 0;
        n_tests++;
        if ({imem_req, imem_addr, id_valid, id_inst} !== {1'b1, 32'h8000_0100, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL drop_discard: req=%b addr=%h valid=%b inst=%h expected 1 80000100 0 0", imem_req, imem_addr, id_valid, id_inst);
        end
        wait_valid(ok);
        n_tests++;
        if (!ok || id_pc !== 32'h8000_0100 || id_inst !== mem_word(32'h8000_0100)) begin
            n_fail++;
            $display("FAIL drop_next_inst: ok=%0d pc=%h inst=%h expected 80000100 %h", ok, id_pc, id_inst, mem_word(32'h8000_0100));
        end
    endtask

    task automatic test_redir_rvalid();
        bit ok;
        mem_lat = 1;
        do_reset();
        @(posedge clk); #2;
        apply_redir(3'b000, 32'h8000_0200, 1'b0, 32'd0, 26'd0, 32'd0);
        n_tests++;
        if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8000_0204}) begin
            n_fail++;
            $display("FAIL redir_rvalid: valid=%b req=%b addr=%h expected 0 1 80000204", id_valid, imem_req, imem_addr);
        end
        wait_valid(ok);
        n_tests++;
        if (!ok || id_pc !== 32'h8000_0204) begin
            n_fail++;
            $display("FAIL redir_rvalid_inst: ok=%0d pc=%h expected 80000204", ok, id_pc);
        end
    endtask

    task automatic test_reset_stray();
        bit ok;
        mem_lat = 3;
        do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; stray = 1;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'hBFC0_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_state: req=%b addr=%h valid=%b expected 1 bfc00000 0", imem_req, imem_addr, id_valid);
        end
        @(posedge clk);
        #1 stray = 0;
        #1;
        n_tests++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_ignored: valid=%b req=%b expected 0 0", id_valid, imem_req);
        end
        wait_valid(ok);
        n_tests++;
        if (!ok || id_pc !== 32'hBFC0_0000 || id_inst !== mem_word(32'hBFC0_0000)) begin
            n_fail++;
            $display("FAIL stray_first_inst: ok=%0d pc=%h inst=%h expected bfc00000 %h", ok, id_pc, id_inst, mem_word(32'hBFC0_0000));
        end
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        id_ready = 1'b1; redir_valid = 1'b0; npc_op = 3'b000; redir_pc = 32'd0;
        br_taken = 1'b0; br_imm = 32'd0; j_index = 26'd0; jr_target = 32'd0;
        test_reset();
        test_backpressure();
        test_branch();
        test_jump();
        test_drop_latency();
        test_redir_rvalid();
        test_reset_stray();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
